// File: rtl/ex_mem_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg_if
//  Description : Bundle of the signals crossing the EX->MEM pipeline boundary.
//                The execute stage drives the ex_* fields and the pipeline
//                controls. The EX/MEM register returns the mem_* fields, the
//                architectural flags and the sticky halt.
//                  master : execute-stage / pipeline-control side
//                  slave  : the EX/MEM pipeline register
//  Ports       : (interface signals)
//                  stall, flush                  pipeline control
//                  ex_valid .. ex_halt           execute-stage outputs
//                  mem_valid .. mem_halt         registered memory-stage view
//                  flag_z, flag_v, flag_n        architectural flags
//                  halted                        sticky halt status
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_mem_reg_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
);
    // Pipeline control
    logic              stall;
    logic              flush;

    // Execute-stage outputs
    logic              ex_valid;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic              ex_ovfl;
    logic              ex_neg;
    logic [2:0]        ex_flag_we;     // {Z, V, N}
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_we;
    logic              ex_mem_re;
    logic              ex_mem_we;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_halt;

    // Memory-stage view
    logic              mem_valid;
    logic [DATA_W-1:0] mem_result;
    logic [REG_W-1:0]  mem_rd;
    logic              mem_reg_we;
    logic              mem_mem_re;
    logic              mem_mem_we;
    logic [DATA_W-1:0] mem_store_data;
    logic              mem_halt;

    // Architectural status
    logic              flag_z;
    logic              flag_v;
    logic              flag_n;
    logic              halted;

    modport master (
        output stall, flush,
        output ex_valid, ex_result, ex_zero, ex_ovfl, ex_neg, ex_flag_we,
        output ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_store_data, ex_halt,
        input  mem_valid, mem_result, mem_rd, mem_reg_we, mem_mem_re,
        input  mem_mem_we, mem_store_data, mem_halt,
        input  flag_z, flag_v, flag_n, halted
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, ex_result, ex_zero, ex_ovfl, ex_neg, ex_flag_we,
        input  ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_store_data, ex_halt,
        output mem_valid, mem_result, mem_rd, mem_reg_we, mem_mem_re,
        output mem_mem_we, mem_store_data, mem_halt,
        output flag_z, flag_v, flag_n, halted
    );
endinterface : ex_mem_reg_if
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_reg
//  Description : EX->MEM pipeline register. Captures the execute result,
//                destination/control bits and store data each cycle. Owns
//                the architectural Z/V/N flags, which change only when a
//                valid instruction commits across the boundary. Supports
//                stall (hold everything), flush (insert a bubble) and a
//                sticky halt that drains the pipeline once HLT commits.
//  Ports       : clk  - clock, all state changes on the rising edge
//                rst  - synchronous active-high reset
//                bus  - ex_mem_reg_if.slave (controls, EX inputs, MEM outputs,
//                       flags, halted)
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_reg #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  wire          clk,
    input  wire          rst,
    ex_mem_reg_if.slave  bus
);

    logic              r_valid;
    logic [DATA_W-1:0] r_result;
    logic [REG_W-1:0]  r_rd;
    logic              r_reg_we;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_store_data;
    logic              r_halt;
    logic              r_flag_z;
    logic              r_flag_v;
    logic              r_flag_n;
    logic              r_halted;

    // A bubble is loaded on flush, and also every cycle after HLT has
    // committed so that nothing younger than the HLT can reach MEM.
    logic w_bubble;
    logic w_commit;

    assign w_bubble = bus.flush | r_halted;
    assign w_commit = bus.ex_valid & ~w_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_rd         <= '0;
            r_reg_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_data <= '0;
            r_halt       <= 1'b0;
            r_flag_z     <= 1'b0;
            r_flag_v     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_halted     <= 1'b0;
        end else if (!bus.stall) begin
            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_result     <= '0;
                r_rd         <= '0;
                r_reg_we     <= 1'b0;
                r_mem_re     <= 1'b0;
                r_mem_we     <= 1'b0;
                r_store_data <= '0;
                r_halt       <= 1'b0;
            end else begin
                // Data fields follow EX unconditionally; control bits are
                // qualified so an invalid slot can never write anything.
                r_valid      <= bus.ex_valid;
                r_result     <= bus.ex_result;
                r_rd         <= bus.ex_rd;
                r_store_data <= bus.ex_store_data;
                r_reg_we     <= bus.ex_reg_we & bus.ex_valid;
                r_mem_re     <= bus.ex_mem_re & bus.ex_valid;
                r_mem_we     <= bus.ex_mem_we & bus.ex_valid;
                r_halt       <= bus.ex_halt   & bus.ex_valid;
            end

            if (w_commit) begin
                if (bus.ex_flag_we[2]) r_flag_z <= bus.ex_zero;
                if (bus.ex_flag_we[1]) r_flag_v <= bus.ex_ovfl;
                if (bus.ex_flag_we[0]) r_flag_n <= bus.ex_neg;
                if (bus.ex_halt)       r_halted <= 1'b1;
            end
        end
    end

    assign bus.mem_valid      = r_valid;
    assign bus.mem_result     = r_result;
    assign bus.mem_rd         = r_rd;
    assign bus.mem_reg_we     = r_reg_we;
    assign bus.mem_mem_re     = r_mem_re;
    assign bus.mem_mem_we     = r_mem_we;
    assign bus.mem_store_data = r_store_data;
    assign bus.mem_halt       = r_halt;
    assign bus.flag_z         = r_flag_z;
    assign bus.flag_v         = r_flag_v;
    assign bus.flag_n         = r_flag_n;
    assign bus.halted         = r_halted;

endmodule : ex_mem_reg
`default_nettype wire

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- Pipeline register between the execute stage (ALU and 16-bit shifter) and the memory stage.
- Captures the execute result, destination/control bits and store data once per cycle.
- Owns the architectural flag register (Z, V, N), updated only when a valid instruction commits across EX->MEM.
- Supports stall (hold), flush (bubble insert) and a sticky halt.

Parameters:
- DATA_W, 16, datapath width of result and store data.
- REG_W, 4, register-specifier width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- flush  input  1  squash the EX instruction; load a bubble.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_result  input  DATA_W  ALU/shifter output.
- ex_zero  input  1  result==0 from ALU or shifter.
- ex_ovfl  input  1  signed overflow from ALU.
- ex_neg  input  1  result sign.
- ex_flag_we  input  3  per-flag write enables {Z,V,N}; a shift op asserts 3'b100.
- ex_rd  input  REG_W  destination register.
- ex_reg_we  input  1  register-file write.
- ex_mem_re  input  1  load.
- ex_mem_we  input  1  store.
- ex_store_data  input  DATA_W  store data.
- ex_halt  input  1  HLT instruction.
- mem_valid  output  1  MEM stage holds a real instruction.
- mem_result  output  DATA_W  registered ex_result.
- mem_rd  output  REG_W  registered ex_rd.
- mem_reg_we  output  1  registered, gated by validity.
- mem_mem_re  output  1  registered, gated by validity.
- mem_mem_we  output  1  registered, gated by validity.
- mem_store_data  output  DATA_W  registered ex_store_data.
- mem_halt  output  1  registered, gated by validity.
- flag_z, flag_v, flag_n  output  1 each  architectural flags.
- halted  output  1  sticky; set once a halt commits.

Behaviour:
- Reset (rst=1 at edge): every output above is 0, including flags and halted. Reset overrides stall and flush; reset mid-stall discards the held instruction.
- Per-edge priority is rst > stall > flush > halted > advance.
- stall=1: all registers, flags and halted hold. flush is ignored that cycle; upstream must re-present the flush after the stall.
- flush=1, stall=0: load a bubble.
  - mem_valid, mem_reg_we, mem_mem_re, mem_mem_we and mem_halt = 0.
  - mem_result, mem_rd and mem_store_data = 0.
  - Flags and halted unchanged.
- halted=1, stall=0, flush=0: load a bubble as for flush, regardless of ex_valid. The pipeline drains; nothing after HLT commits.
- Advance (stall=0, flush=0, halted=0):
  - mem_valid <= ex_valid. Data fields load unconditionally.
  - Control bits (reg_we, mem_re, mem_we, halt) load ANDed with ex_valid.
  - Result latency: one cycle.
- Flag update happens only on an advance with ex_valid=1.
  - flag_z <= ex_zero if ex_flag_we[2].
  - flag_v <= ex_ovfl if ex_flag_we[1].
  - flag_n <= ex_neg if ex_flag_we[0].
  - Disabled flags hold. Flags are visible the cycle after commit.
- Halt: advance with ex_valid=1 and ex_halt=1 sets mem_halt=1 and halted=1 on the same edge. halted stays 1 until rst; mem_halt returns to 0 on the next non-stalled edge.
- Simultaneous-event rules:
  - ex_mem_re and ex_mem_we both 1: both are passed through. Exclusivity is decode's responsibility.
  - ex_valid=0 with nonzero ex_flag_we: no flag change.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: drive all inputs to 1 and pulse rst for 2 cycles -> every output is 0 after the first edge; rst with stall=1 still clears.
- Advance and flags:
  - ex_valid=1, ex_result=16'h0000, ex_zero=1, ex_flag_we=3'b100, ex_rd=4'h5, ex_reg_we=1 -> next cycle mem_result=0, mem_rd=5, mem_reg_we=1, flag_z=1, flag_v and flag_n unchanged.
  - Then ex_result=16'h8000, ex_neg=1, ex_ovfl=1, ex_flag_we=3'b111 -> flag_z=0, flag_v=1, flag_n=1.
- Stall hold:
  - Load ex_result=16'h1234, then stall=1 for 3 cycles while inputs change to 16'hFFFF with ex_flag_we=3'b111 -> mem_result stays 16'h1234 and flags stay frozen.
  - Release stall -> 16'hFFFF loads.
- Flush and stall+flush:
  - flush=1 with ex_valid=1, ex_mem_we=1, ex_flag_we=3'b111 -> mem_valid=0, mem_mem_we=0, mem_result=0, flags unchanged.
  - stall=1 and flush=1 together -> previous contents held.
- Invalid gating: ex_valid=0, ex_reg_we=1, ex_flag_we=3'b111, ex_zero=1 -> mem_reg_we=0, mem_valid=0, flag_z unchanged.
- Halt:
  - ex_valid=1, ex_halt=1 -> mem_halt=1 and halted=1.
  - Next cycle, with ex_valid=1 and ex_reg_we=1 -> mem_valid=0, mem_halt=0, halted remains 1.
  - rst -> halted=0.
